fpcvt_seq: RTL

FPCVT_SEQ -- requirements
Module: fpcvt_seq

---
 rtl/fpcvt_pkg.sv | 18 +
 rtl/fpcvt_round.sv | 55 +++++
 rtl/fpcvt_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg
//   Shared definitions for the fpcvt_seq integer-to-float converter.
//   - state_t      : control states of the converter
//                    (IDLE, NORM, DONE)
//   - RND_TRUNC    : rounding mode, drop the guard bit
//   - RND_HALF_UP  : rounding mode, add the guard bit to the mantissa
package fpcvt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

endpackage

// File: rtl/fpcvt_round.sv
// fpcvt_round
//   Combinational rounding and saturation stage of the converter.
//   Takes the normalised mantissa window, the guard bit just below it
//   and the current exponent, and produces the final mantissa/exponent.
//
//   Parameters
//     MW : mantissa width
//     EW : exponent width
//
//   Ports
//     i_mant      in  MW  truncated mantissa window
//     i_guard     in  1   first bit below the mantissa window
//     i_roundMode in  1   RND_HALF_UP adds the guard bit, RND_TRUNC ignores it
//     i_exp       in  EW  exponent before rounding
//     o_mant      out MW  rounded (or saturated) mantissa
//     o_exp       out EW  exponent after any rounding carry
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int MW = 4,
    parameter int EW = 3
) (
    input  logic [MW-1:0] i_mant,
    input  logic          i_guard,
    input  logic          i_roundMode,
    input  logic [EW-1:0] i_exp,
    output logic [MW-1:0] o_mant,
    output logic [EW-1:0] o_exp
);

    logic          w_roundBit;
    logic [MW:0]   w_sum;

    // The adder is one bit wider than the mantissa so the carry-out
    // tells us the mantissa wrapped from all ones to zero. On a carry
    // the value doubles: renormalise to 100..0 and bump the exponent,
    // unless the exponent is already at its maximum, in which case the
    // largest representable value is returned instead.
    always_comb begin
        w_roundBit = (i_roundMode == RND_HALF_UP) ? i_guard : 1'b0;
        w_sum      = {1'b0, i_mant} + {{MW{1'b0}}, w_roundBit};
        o_mant     = w_sum[MW-1:0];
        o_exp      = i_exp;
        if (w_sum[MW]) begin
            if (i_exp == {EW{1'b1}}) begin
                o_mant = {MW{1'b1}};
                o_exp  = {EW{1'b1}};
            end else begin
                o_mant = MW'(1) << (MW - 1);
                o_exp  = i_exp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_seq.sv
// fpcvt_seq
//   Sequential converter from a W-bit two's-complement integer to a small
//   sign/exponent/mantissa format, value ~= (-1)^s * f * 2^e.
//   The magnitude is normalised by shifting left one bit per clock until
//   its top bit is set or the exponent counter reaches zero, then the
//   mantissa is rounded (optionally) and held until the consumer takes it.
//
//   Parameters
//     W  : input width (must equal MW + 2**EW)
//     MW : mantissa width
//     EW : exponent width
//
//   Ports
//     clk        in  1   clock, rising edge
//     rst_n      in  1   asynchronous active-low reset
//     in_valid   in  1   input word offered
//     in_ready   out 1   converter idle and able to accept
//     d          in  W   two's-complement sample
//     round_en   in  1   1 = round half up, 0 = truncate (taken with d)
//     out_valid  out 1   result available on s/e/f
//     out_ready  in  1   consumer takes the result
//     s          out 1   sign
//     e          out EW  exponent
//     f          out MW  mantissa
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter int W  = 12,
    parameter int MW = 4,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  d,
    input  logic          round_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          s,
    output logic [EW-1:0] e,
    output logic [MW-1:0] f
);

    localparam int MAGW = W - 1;

    // The mantissa window plus one exponent step per shift must exactly
    // cover the magnitude, otherwise the normalisation range is wrong.
    generate
        if (W != MW + 2**EW) begin : g_badWidth
            $error("fpcvt_seq: parameter W must equal MW + 2**EW");
        end
    endgenerate

    state_t              r_state;
    state_t              w_nextState;
    logic                w_accept;
    logic                w_shift;
    logic                w_finish;

    logic [MAGW-1:0]     r_mag;
    logic [EW-1:0]       r_cnt;
    logic                r_sign;
    logic                r_roundMode;
    logic                r_s;
    logic [EW-1:0]       r_e;
    logic [MW-1:0]       r_f;

    logic [MAGW-1:0]     w_magIn;
    logic [MAGW-1:0]     w_negLow;
    logic [MW-1:0]       w_rndMant;
    logic [EW-1:0]       w_rndExp;

    // Magnitude of the incoming sample in W-1 bits. Negating only the
    // low W-1 bits is enough for every negative value except the most
    // negative one, which is recognised by its all-zero low bits and
    // saturated to the largest magnitude instead.
    always_comb begin
        w_negLow = (~d[MAGW-1:0]) + {{(MAGW-1){1'b0}}, 1'b1};
        if (!d[W-1]) begin
            w_magIn = d[MAGW-1:0];
        end else if (d[MAGW-1:0] == '0) begin
            w_magIn = {MAGW{1'b1}};
        end else begin
            w_magIn = w_negLow;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and datapath strobes. NORM finishes as soon as
    // the magnitude is normalised or the exponent cannot go lower, so a
    // conversion performs between 0 and 2**EW-1 shifts.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = NORM;
                end
            end
            NORM: begin
                if (r_mag[MAGW-1] || (r_cnt == '0)) begin
                    w_finish    = 1'b1;
                    w_nextState = DONE;
                end else begin
                    w_shift     = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    fpcvt_round #(
        .MW (MW),
        .EW (EW)
    ) u_round (
        .i_mant      (r_mag[MAGW-1 -: MW]),
        .i_guard     (r_mag[MAGW-1-MW]),
        .i_roundMode (r_roundMode),
        .i_exp       (r_cnt),
        .o_mant      (w_rndMant),
        .o_exp       (w_rndExp)
    );

    // Working registers for the conversion in flight and the result
    // registers. The sign is kept in r_sign during NORM so that s/e/f
    // only change when a new result is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_roundMode <= RND_TRUNC;
            r_s         <= 1'b0;
            r_e         <= '0;
            r_f         <= '0;
        end else begin
            if (w_accept) begin
                r_mag       <= w_magIn;
                r_cnt       <= {EW{1'b1}};
                r_sign      <= d[W-1];
                r_roundMode <= round_en ? RND_HALF_UP : RND_TRUNC;
            end
            if (w_shift) begin
                r_mag <= {r_mag[MAGW-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_s <= r_sign;
                r_e <= w_rndExp;
                r_f <= w_rndMant;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign e         = r_e;
    assign f         = r_f;

endmodule
